tournament_resolve_queue: RTL and testbench
===========================================

// Module: tournament_resolve_queue
// PURPOSE
//  Final stage of the tournament predictor; consumes GlobalBit/ChoiceBit from the global/choice stage and LocalBit from the local stage.
//  Selects PredictedBranch and queues each in-flight prediction (global, local, choice, final) in FIFO order.
//  On branch resolution, pops the oldest entry and produces registered training/update signals for the predictor tables.
//  Optionally keeps branch and mispredict statistics.
// PARAMETERS
//  DEPTH  8   in-flight prediction entries; power of 2, >=2
//  CNT_W  16  width of statistics counters
// PORTS
//  clock            in   1      single clock, all logic on posedge
//  reset            in   1      synchronous, active-high
//  pred_valid       in   1      new branch predicted this cycle
//  GlobalBit        in   1      global-history prediction
//  LocalBit         in   1      local-history prediction
//  ChoiceBit        in   1      1 = trust global, 0 = trust local
//  pred_ready       out  1      queue can accept (not full)
//  PredictedBranch  out  1      registered final prediction
//  pred_out_valid   out  1      PredictedBranch valid (1-cycle pulse)
//  resolve_valid    in   1      oldest branch resolved this cycle
//  BranchTaken      in   1      actual outcome of resolving branch
//  flush            in   1      discard all in-flight entries
//  upd_valid        out  1      update outputs valid (1-cycle pulse)
//  mispredict       out  1      final prediction != BranchTaken
//  global_correct   out  1      queued GlobalBit == BranchTaken
//  local_correct    out  1      queued LocalBit == BranchTaken
//  choice_upd_en    out  1      global and local disagreed; train chooser
//  choice_dir       out  1      1 = global was right (valid with choice_upd_en)
//  occupancy        out  $clog2(DEPTH)+1  current entry count
//  overflow_err     out  1      sticky: push attempted while full
//  underflow_err    out  1      sticky: resolve attempted while empty
//  branch_count     out  CNT_W  resolved branches (feature-gated)
//  mispred_count    out  CNT_W  mispredicted branches (feature-gated)
// BEHAVIOUR
//  - Reset: all outputs 0, pointers 0, occupancy 0, sticky errors cleared, pred_ready=1. Reset mid-operation drops all entries.
//  - sel = ChoiceBit ? GlobalBit : LocalBit.
//  - Push: pred_valid && pred_ready. Store {GlobalBit,LocalBit,ChoiceBit,sel} at wr_ptr; wr_ptr++.
//    Next cycle: PredictedBranch=sel, pred_out_valid=1.
//  - pred_ready = (occupancy != DEPTH), from registered occupancy only.
//    A same-cycle pop does not make room.
//  - Push while full: entry dropped, overflow_err<=1, no pred_out_valid.
//  - Pop: resolve_valid && occupancy!=0. Read entry at rd_ptr; rd_ptr++.
//    Next cycle: upd_valid=1 and mispredict/global_correct/local_correct computed against BranchTaken.
//    choice_upd_en = (G!=L); choice_dir = (G==BranchTaken).
//  - Pop while empty: no upd_valid, underflow_err<=1.
//  - Simultaneous push+pop (not full, not empty): both occur; occupancy unchanged.
//    Push+pop at occupancy 0: pop is underflow; push succeeds.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
//  - flush: next cycle pointers=0 and occupancy=0. Same-cycle push and pop are ignored; no pulses, no error set.
//    Sticky errors and counters are kept.
//  - Outputs not pulsed hold 0 (upd_valid, pred_out_valid); data outputs hold their last value.
//  - Sticky errors clear only on reset.
// CONFIGURATION
//  TOURN_STATS_EN defined:
//    branch_count++ on each valid pop; mispred_count++ when that pop mispredicts.
//    Both saturate at 2^CNT_W-1. Counters update in the same cycle as upd_valid.
//  TOURN_STATS_EN undefined: no counter flops; branch_count and mispred_count tied to 0.
// TESTING
//  - Reset, then push G=1,L=0,C=1 -> next cycle PredictedBranch=1, pred_out_valid=1, occupancy=1.
//  - Resolve with BranchTaken=0 -> upd_valid=1, mispredict=1, global_correct=0, local_correct=1,
//    choice_upd_en=1, choice_dir=0; mispred_count=1 with TOURN_STATS_EN.
//  - Push 8 entries (DEPTH=8) -> pred_ready=0. 9th push -> overflow_err=1, occupancy stays 8.
//    Pop 8 -> FIFO order preserved across pointer wrap.
//  - Resolve at occupancy 0 -> underflow_err=1, no upd_valid. Push+pop at occupancy 3 -> occupancy stays 3.
//  - flush with pred_valid=1 at occupancy 5 -> occupancy=0, no pred_out_valid; the next resolve flags underflow.
//  - Preload branch_count to max-1 (CNT_W=4), resolve 3 branches -> saturates at 15.
//    Build without TOURN_STATS_EN -> counters read 0.

Source files
------------

// File: rtl/tournament_resolve_queue.sv
// Tournament predictor final stage: picks global/local by chooser, queues in-flight predictions, emits training on resolve.
// One-cycle latency on both prediction and update; pred_ready drops when full. Optional counters under TOURN_STATS_EN.
module tournament_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic                     GlobalBit,
  input  logic                     LocalBit,
  input  logic                     ChoiceBit,
  output logic                     pred_ready,
  output logic                     PredictedBranch,
  output logic                     pred_out_valid,
  input  logic                     resolve_valid,
  input  logic                     BranchTaken,
  input  logic                     flush,
  output logic                     upd_valid,
  output logic                     mispredict,
  output logic                     global_correct,
  output logic                     local_correct,
  output logic                     choice_upd_en,
  output logic                     choice_dir,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispred_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  typedef struct packed {
    logic globalBit;
    logic localBit;
    logic choiceBit;
    logic finalBit;
  } entry_t;

  entry_t        entryMem [DEPTH];
  entry_t        headEntry;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          selBit;
  logic          doPush;
  logic          doPop;
  logic          isEmpty;

  assign selBit     = ChoiceBit ? GlobalBit : LocalBit;
  assign isEmpty    = (occupancy == '0);
  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign pred_ready = (occupancy != OW'(DEPTH));
  assign doPush     = pred_valid && pred_ready && !flush;
  assign doPop      = resolve_valid && !isEmpty && !flush;
  assign headEntry  = entryMem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) begin
      entryMem[wrPtr] <= '{globalBit: GlobalBit, localBit: LocalBit,
                           choiceBit: ChoiceBit, finalBit: selBit};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr           <= '0;
      rdPtr           <= '0;
      occupancy       <= '0;
      overflow_err    <= 1'b0;
      underflow_err   <= 1'b0;
      PredictedBranch <= 1'b0;
      pred_out_valid  <= 1'b0;
      upd_valid       <= 1'b0;
      mispredict      <= 1'b0;
      global_correct  <= 1'b0;
      local_correct   <= 1'b0;
      choice_upd_en   <= 1'b0;
      choice_dir      <= 1'b0;
    end else begin
      pred_out_valid <= doPush;
      upd_valid      <= doPop;
      if (flush) begin
        wrPtr     <= '0;
        rdPtr     <= '0;
        occupancy <= '0;
      end else begin
        if (pred_valid && !pred_ready) overflow_err  <= 1'b1;
        if (resolve_valid && isEmpty)  underflow_err <= 1'b1;
        if (doPush) begin
          wrPtr           <= wrPtr + PW'(1);
          PredictedBranch <= selBit;
        end
        if (doPop) begin
          rdPtr          <= rdPtr + PW'(1);
          mispredict     <= (headEntry.finalBit != BranchTaken);
          global_correct <= (headEntry.globalBit == BranchTaken);
          local_correct  <= (headEntry.localBit == BranchTaken);
          choice_upd_en  <= (headEntry.globalBit != headEntry.localBit);
          choice_dir     <= (headEntry.globalBit == BranchTaken);
        end
        occupancy <= occupancy + OW'(doPush) - OW'(doPop);
      end
    end
  end

`ifdef TOURN_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else if (doPop) begin
      if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
      if ((headEntry.finalBit != BranchTaken) && (mispred_count != '1))
        mispred_count <= mispred_count + CNT_W'(1);
    end
  end
`else
  assign branch_count  = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_tournament_resolve_queue.sv
// Bench for tournament_resolve_queue: queue-based reference model compared every cycle plus literal checks.
module tb_tournament_resolve_queue;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int CNTMAX = 15;

  logic clock, reset;
  logic pred_valid, GlobalBit, LocalBit, ChoiceBit;
  logic pred_ready, PredictedBranch, pred_out_valid;
  logic resolve_valid, BranchTaken, flush;
  logic upd_valid, mispredict, global_correct, local_correct, choice_upd_en, choice_dir;
  logic [3:0] occupancy;
  logic overflow_err, underflow_err;
  logic [CNT_W-1:0] branch_count, mispred_count;

  tournament_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .GlobalBit(GlobalBit), .LocalBit(LocalBit), .ChoiceBit(ChoiceBit),
    .pred_ready(pred_ready), .PredictedBranch(PredictedBranch), .pred_out_valid(pred_out_valid),
    .resolve_valid(resolve_valid), .BranchTaken(BranchTaken), .flush(flush),
    .upd_valid(upd_valid), .mispredict(mispredict), .global_correct(global_correct),
    .local_correct(local_correct), .choice_upd_en(choice_upd_en), .choice_dir(choice_dir),
    .occupancy(occupancy), .overflow_err(overflow_err), .underflow_err(underflow_err),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {G,L,C,final} entries.
  logic [3:0] q[$];
  bit mPred, mPov, mUpd, mMis, mGc, mLc, mCue, mCd, mOvf, mUnf;
  int mBc, mMc;

  always @(posedge clock) begin
    int n;
    logic [3:0] e;
    logic s;
    if (reset) begin
      q.delete();
      {mPred, mPov, mUpd, mMis, mGc, mLc, mCue, mCd, mOvf, mUnf} = '0;
      mBc = 0; mMc = 0;
    end else begin
      mPov = 0; mUpd = 0;
      if (flush) q.delete();
      else begin
        n = q.size();
        if (resolve_valid) begin
          if (n == 0) mUnf = 1;
          else begin
            e = q.pop_front();
            mUpd = 1;
            mMis = (e[0] != BranchTaken);
            mGc  = (e[3] == BranchTaken);
            mLc  = (e[2] == BranchTaken);
            mCue = (e[3] != e[2]);
            mCd  = (e[3] == BranchTaken);
`ifdef TOURN_STATS_EN
            if (mBc < CNTMAX) mBc++;
            if (mMis && mMc < CNTMAX) mMc++;
`endif
          end
        end
        if (pred_valid) begin
          if (n == DEPTH) mOvf = 1;
          else begin
            s = ChoiceBit ? GlobalBit : LocalBit;
            q.push_back({GlobalBit, LocalBit, ChoiceBit, s});
            mPov = 1;
            mPred = s;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chkEn) begin
      chk("pred_ready", pred_ready, q.size() != DEPTH);
      chk("occupancy", occupancy, q.size());
      chk("pred_out_valid", pred_out_valid, mPov);
      chk("PredictedBranch", PredictedBranch, mPred);
      chk("upd_valid", upd_valid, mUpd);
      chk("mispredict", mispredict, mMis);
      chk("global_correct", global_correct, mGc);
      chk("local_correct", local_correct, mLc);
      chk("choice_upd_en", choice_upd_en, mCue);
      chk("choice_dir", choice_dir, mCd);
      chk("overflow_err", overflow_err, mOvf);
      chk("underflow_err", underflow_err, mUnf);
      chk("branch_count", branch_count, mBc);
      chk("mispred_count", mispred_count, mMc);
    end
  end

  task automatic cyc(input bit pv, input bit g, input bit l, input bit c,
                     input bit rv, input bit bt, input bit fl, input bit rs);
    pred_valid = pv; GlobalBit = g; LocalBit = l; ChoiceBit = c;
    resolve_valid = rv; BranchTaken = bt; flush = fl; reset = rs;
    @(posedge clock);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chkEn = 1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_pred_ready", pred_ready, 1);
    chk("rst_upd_valid", upd_valid, 0);

    // G=1 L=0 C=1 picks global -> 1
    cyc(1, 1, 0, 1, 0, 0, 0, 0);
    chk("lit_pred", PredictedBranch, 1);
    chk("lit_pov", pred_out_valid, 1);
    chk("lit_occ1", occupancy, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("lit_upd", upd_valid, 1);
    chk("lit_mis", mispredict, 1);
    chk("lit_gc", global_correct, 0);
    chk("lit_lc", local_correct, 1);
    chk("lit_cue", choice_upd_en, 1);
    chk("lit_cd", choice_dir, 0);
`ifdef TOURN_STATS_EN
    chk("lit_mcnt", mispred_count, 1);
`else
    chk("lit_mcnt_off", mispred_count, 0);
`endif

    // Fill to DEPTH (pointers start at 1, so draining wraps).
    for (int i = 0; i < DEPTH; i++) cyc(1, i[0], i[1], i[2], 0, 0, 0, 0);
    chk("lit_full_ready", pred_ready, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    chk("lit_ovf", overflow_err, 1);
    chk("lit_occ8", occupancy, 8);
    chk("lit_ovf_pov", pred_out_valid, 0);
    // Pop while full plus push: push still dropped.
    cyc(1, 1, 1, 1, 1, 1, 0, 0);
    chk("lit_full_pp_occ", occupancy, 7);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, i[1], 0, 0);
    chk("lit_empty", occupancy, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("lit_unf", underflow_err, 1);
    chk("lit_unf_upd", upd_valid, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 1, 0, 0);
    chk("lit_pp_occ3", occupancy, 3);

    // Reset mid-operation, then flush at occupancy 5 with a push.
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_rst_occ", occupancy, 0);
    chk("lit_rst_ovf", overflow_err, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 0, 1, 0);
    chk("lit_flush_occ", occupancy, 0);
    chk("lit_flush_pov", pred_out_valid, 0);
    chk("lit_flush_unf", underflow_err, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("lit_flush_then_unf", underflow_err, 1);

    // Simultaneous push+pop at empty: pop underflows, push lands.
    cyc(1, 0, 1, 0, 1, 0, 0, 0);
    chk("lit_pp0_occ", occupancy, 1);
    chk("lit_pp0_upd", upd_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 99) < 50, $urandom_range(0, 1),
          $urandom_range(0, 99) < 2, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef TOURN_STATS_EN
    chk("lit_bc_sat", branch_count, 15);
`else
    chk("lit_bc_off", branch_count, 0);
`endif
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
